// File: rtl/spram_16kx16_model_if.sv
// spram_16kx16_model_if: access/power bus of the 16K x 16 single-port RAM model; SPRAM_ACCESS_CHECK_EN adds access_err
interface spram_16kx16_model_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16
) ();
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   din;
    logic [DATA_W/4-1:0] maskwren;
    logic                wren;
    logic                cs;
    logic                standby;
    logic                sleep;
    logic                poweroff;
    logic [DATA_W-1:0]   dout;
`ifdef SPRAM_ACCESS_CHECK_EN
    logic                access_err;
    modport master (output addr, din, maskwren, wren, cs, standby, sleep, poweroff, input dout, access_err);
    modport slave (input addr, din, maskwren, wren, cs, standby, sleep, poweroff, output dout, access_err);
`else
    modport master (output addr, din, maskwren, wren, cs, standby, sleep, poweroff, input dout);
    modport slave (input addr, din, maskwren, wren, cs, standby, sleep, poweroff, output dout);
`endif
endinterface

// File: rtl/spram_16kx16_model.sv
// spram_16kx16_model: iCE40UP SPRAM model, 1-cycle read, nibble write mask, sleep/standby/poweroff; SPRAM_ACCESS_CHECK_EN adds access_err
module spram_16kx16_model #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16
) (
    input logic clk,
    input logic rst,
    spram_16kx16_model_if.slave bus
);
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int MASK_W = DATA_W / 4;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [DATA_W-1:0] dout_q, dout_d, old_word, wr_word;
    logic              active, rd, wr;

    // a word never written since the last clear reads as zero; unmasked nibbles keep that view
    always_comb begin
        old_word = valid_q[bus.addr] ? mem_q[bus.addr] : '0;
        wr_word  = old_word;
        for (int i = 0; i < MASK_W; i++)
            wr_word[4*i +: 4] = bus.maskwren[i] ? bus.din[4*i +: 4] : old_word[4*i +: 4];
        active = !rst && bus.poweroff && !bus.sleep && !bus.standby && bus.cs;
        rd     = active && !bus.wren;
        wr     = active && bus.wren && |bus.maskwren;
        dout_d = (!bus.poweroff || bus.sleep) ? '0 : rd ? old_word : dout_q;
    end

    // array contents are never reset; validity bits govern what reads return
    always_ff @(posedge clk) begin
        if (wr)
            mem_q[bus.addr] <= wr_word;
    end

    // reset and power loss invalidate every word at once
    always_ff @(posedge clk) begin
        if (rst || !bus.poweroff)
            valid_q <= '0;
        else if (wr)
            valid_q[bus.addr] <= 1'b1;
    end

    // registered read data
    always_ff @(posedge clk) begin
        if (rst)
            dout_q <= '0;
        else
            dout_q <= dout_d;
    end

    assign bus.dout = dout_q;

`ifdef SPRAM_ACCESS_CHECK_EN
    logic err_q, err_d;

    // flag selects while not accessible, and reads of invalid words
    always_comb begin
        err_d = (bus.cs && (bus.sleep || bus.standby || !bus.poweroff)) || (rd && !valid_q[bus.addr]);
    end

    // one-cycle registered error pulse
    always_ff @(posedge clk) begin
        if (rst)
            err_q <= 1'b0;
        else
            err_q <= err_d;
    end

    assign bus.access_err = err_q;
`endif
endmodule

// File: tb/tb_spram_16kx16_model.sv
// tb_spram_16kx16_model: table-driven directed checks plus full-array load/reset/reload sequence
module tb_spram_16kx16_model;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    spram_16kx16_model_if bus ();

    spram_16kx16_model dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic        r, pwr, slp, stb, cs, we;
        logic [3:0]  mask;
        logic [13:0] addr;
        logic [15:0] din;
        logic [15:0] dout;
        logic        err;
    } vec_t;

    vec_t v[30];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, pwr, slp, stb, cs, we, input logic [3:0] mask,
                        input logic [13:0] addr, input logic [15:0] din);
        @(negedge clk);
        rst = r; bus.poweroff = pwr; bus.sleep = slp; bus.standby = stb;
        bus.cs = cs; bus.wren = we; bus.maskwren = mask; bus.addr = addr; bus.din = din;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; bus.poweroff = 1'b1; bus.sleep = 1'b0; bus.standby = 1'b0;
        bus.cs = 1'b0; bus.wren = 1'b0; bus.maskwren = '0; bus.addr = '0; bus.din = '0;
        //        r  pwr slp stb cs we mask     addr      din       dout      err
        v[0]  = '{1, 1, 0, 0, 0, 0, 4'h0, 14'd0,     16'h0000, 16'h0000, 0};
        v[1]  = '{0, 1, 0, 0, 1, 1, 4'hF, 14'd0,     16'hABCD, 16'h0000, 0};
        v[2]  = '{0, 1, 0, 0, 1, 0, 4'h0, 14'd0,     16'h0000, 16'hABCD, 0};
        v[3]  = '{0, 1, 0, 0, 1, 1, 4'h3, 14'd0,     16'h1234, 16'hABCD, 0};
        v[4]  = '{0, 1, 0, 0, 1, 0, 4'h0, 14'd0,     16'h0000, 16'hAB34, 0};
        v[5]  = '{0, 1, 0, 0, 1, 1, 4'h0, 14'd0,     16'hFFFF, 16'hAB34, 0};
        v[6]  = '{0, 1, 0, 0, 1, 0, 4'h0, 14'd0,     16'h0000, 16'hAB34, 0};
        v[7]  = '{0, 1, 0, 0, 1, 1, 4'hF, 14'd16383, 16'h5A5A, 16'hAB34, 0};
        v[8]  = '{0, 1, 0, 0, 1, 1, 4'hF, 14'd0,     16'h0001, 16'hAB34, 0};
        v[9]  = '{0, 1, 0, 0, 1, 0, 4'h0, 14'd16383, 16'h0000, 16'h5A5A, 0};
        v[10] = '{0, 1, 0, 0, 1, 0, 4'h0, 14'd0,     16'h0000, 16'h0001, 0};
        v[11] = '{0, 1, 0, 0, 1, 0, 4'h0, 14'd5,     16'h0000, 16'h0000, 1};
        v[12] = '{0, 1, 0, 0, 1, 0, 4'h0, 14'd16383, 16'h0000, 16'h5A5A, 0};
        v[13] = '{0, 1, 1, 0, 1, 0, 4'h0, 14'd0,     16'h0000, 16'h0000, 1};
        v[14] = '{0, 1, 0, 0, 1, 0, 4'h0, 14'd0,     16'h0000, 16'h0001, 0};
        v[15] = '{0, 1, 0, 1, 1, 0, 4'h0, 14'd16383, 16'h0000, 16'h0001, 1};
        v[16] = '{0, 1, 0, 1, 0, 0, 4'h0, 14'd16383, 16'h0000, 16'h0001, 0};
        v[17] = '{0, 1, 0, 0, 0, 1, 4'hF, 14'd0,     16'h7777, 16'h0001, 0};
        v[18] = '{0, 1, 0, 0, 1, 0, 4'h0, 14'd0,     16'h0000, 16'h0001, 0};
        v[19] = '{0, 1, 1, 0, 1, 1, 4'hF, 14'd0,     16'h9999, 16'h0000, 1};
        v[20] = '{0, 1, 0, 0, 1, 0, 4'h0, 14'd0,     16'h0000, 16'h0001, 0};
        v[21] = '{0, 0, 0, 0, 0, 0, 4'h0, 14'd0,     16'h0000, 16'h0000, 0};
        v[22] = '{0, 1, 0, 0, 1, 0, 4'h0, 14'd0,     16'h0000, 16'h0000, 1};
        v[23] = '{0, 1, 0, 0, 1, 1, 4'h1, 14'd0,     16'h00C3, 16'h0000, 0};
        v[24] = '{0, 1, 0, 0, 1, 0, 4'h0, 14'd0,     16'h0000, 16'h0003, 0};
        v[25] = '{0, 1, 0, 0, 1, 1, 4'h0, 14'd1,     16'hFFFF, 16'h0003, 0};
        v[26] = '{0, 1, 0, 0, 1, 0, 4'h0, 14'd1,     16'h0000, 16'h0000, 1};
        v[27] = '{1, 1, 0, 0, 1, 1, 4'hF, 14'd2,     16'h1111, 16'h0000, 0};
        v[28] = '{0, 1, 0, 0, 1, 0, 4'h0, 14'd2,     16'h0000, 16'h0000, 1};
        v[29] = '{0, 1, 0, 0, 1, 0, 4'h0, 14'd16383, 16'h0000, 16'h0000, 1};
        for (int i = 0; i < 30; i++) begin
            step(v[i].r, v[i].pwr, v[i].slp, v[i].stb, v[i].cs, v[i].we, v[i].mask, v[i].addr, v[i].din);
            check($sformatf("vec%0d dout", i), bus.dout, v[i].dout);
`ifdef SPRAM_ACCESS_CHECK_EN
            check($sformatf("vec%0d access_err", i), 16'(bus.access_err), 16'(v[i].err));
`endif
        end
        // full load with data = address, back-to-back writes
        for (int a = 0; a < 16384; a++)
            step(0, 1, 0, 0, 1, 1, 4'hF, 14'(a), 16'(a));
        for (int a = 0; a < 100; a++) begin
            step(0, 1, 0, 0, 1, 0, 4'h0, 14'(a * 163), 16'h0);
            check($sformatf("load rd %0d", a * 163), bus.dout, 16'(a * 163));
        end
        step(1, 1, 0, 0, 1, 0, 4'h0, 14'd100, 16'h0);
        check("rst mid-stream dout", bus.dout, 16'h0000);
        for (int a = 0; a < 16384; a++) begin
            step(0, 1, 0, 0, 1, 0, 4'h0, 14'(a), 16'h0);
            check($sformatf("cleared rd %0d", a), bus.dout, 16'h0000);
        end
        for (int a = 0; a < 16384; a++)
            step(0, 1, 0, 0, 1, 1, 4'hF, 14'(a), 16'(a));
        for (int a = 0; a < 16384; a++) begin
            step(0, 1, 0, 0, 1, 0, 4'h0, 14'(a), 16'h0);
            check($sformatf("reload rd %0d", a), bus.dout, 16'(a));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
